// File: rtl/button_conditioner.sv
// Pushbutton conditioner: two-flop sync, polarity normalisation, counter debounce,
// press/release pulses and a sticky, software-acknowledged interrupt flag per channel.
module button_conditioner #(
  parameter int          N               = 4,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  input  logic [N-1:0] irq_ack,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] irq
);

  localparam logic [N-1:0] INACTIVE = {N{ACTIVE_LOW}};
  localparam logic [15:0]  LAST_CNT = DEBOUNCE_CYCLES - 16'd1;

  logic [N-1:0] sync1_q, sync2_q;
  logic [N-1:0] state_q, state_d;
  logic [N-1:0] press_q, press_d;
  logic [N-1:0] release_q, release_d;
  logic [N-1:0] irq_q, irq_d;
  logic [15:0]  cnt_q [N];
  logic [15:0]  cnt_d [N];
  logic [N-1:0] samp;

  always_comb begin
    samp    = sync2_q ^ {N{ACTIVE_LOW}};
    state_d = state_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (samp[i] == state_q[i]) begin
        cnt_d[i] = 16'd0;
      end else if (cnt_q[i] >= LAST_CNT) begin
        state_d[i] = samp[i];
        cnt_d[i]   = 16'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
    press_d   = state_d & ~state_q;
    release_d = ~state_d & state_q;
    // A press on the same edge as an acknowledge keeps the flag set.
    irq_d     = press_d | (irq_q & ~irq_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= INACTIVE;
      sync2_q   <= INACTIVE;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      irq_q     <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 16'd0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      irq_q     <= irq_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pressed       = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign irq           = irq_q;

endmodule
